// File: rtl/npu_mem_arbiter.sv
// npu_mem_arbiter
//   Round-robin owner of the NPU external memory port. Requesters are
//   granted whole bursts (capped at MAX_BURST beats); each beat walks
//   ISSUE -> WAIT (until mem_ready) -> STEP, then ownership is returned
//   through RELEASE -> IDLE and priority rotates past the last owner.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   req_valid/we/last          per-requester request, direction, last beat
//   req_addr/req_wdata         flattened per-requester address / write data
//   gnt                        one-hot grant, held for the whole burst
//   rsp_valid, rsp_rdata       one-cycle beat-complete pulse, read data
//   mem_addr/data_out/we/re    external memory request (strobes held)
//   mem_data_in, mem_ready     external memory response
//   busy, owner                FSM not idle, current/last owner index
module npu_mem_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ-1:0]              req_last,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_data_out,
  output logic                            mem_we,
  output logic                            mem_re,
  input  logic [DATA_WIDTH-1:0]           mem_data_in,
  input  logic                            mem_ready,
  output logic                            busy,
  output logic [$clog2(NUM_REQ)-1:0]      owner
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW:0] MAXB = (BW+1)'(MAX_BURST);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, STEP, RELEASE} state_t;

  state_t state, state_nxt;

  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_lane;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_lane;

  logic [OW-1:0]      rr_ptr;
  logic [BW-1:0]      beat_cnt;
  logic [BW:0]        beat_nxt;
  logic               last_q;
  logic               burst_done;

  logic [NUM_REQ-1:0] rot;
  logic [OW-1:0]      pick_off;
  logic [OW:0]        pick_sum;
  logic [OW-1:0]      pick;
  logic [OW-1:0]      owner_inc;

  assign addr_lane  = req_addr;
  assign wdata_lane = req_wdata;

  // Rotate the request vector so rr_ptr sits at bit 0, take the lowest set
  // bit as an offset, then rotate the offset back into a requester index.
  always_comb begin
    rot      = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
    pick_off = '0;
    for (int k = NUM_REQ-1; k >= 0; k--)
      if (rot[k]) pick_off = OW'(k);
    pick_sum = {1'b0, rr_ptr} + {1'b0, pick_off};
    if (pick_sum >= (OW+1)'(NUM_REQ)) pick_sum = pick_sum - (OW+1)'(NUM_REQ);
  end

  assign pick       = pick_sum[OW-1:0];
  assign owner_inc  = (owner == OW'(NUM_REQ-1)) ? '0 : owner + OW'(1);
  assign beat_nxt   = {1'b0, beat_cnt} + (BW+1)'(1);
  assign burst_done = last_q || (beat_nxt >= MAXB);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (|req_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = req_valid[owner] ? WAIT : RELEASE;
      WAIT:    if (mem_ready) state_nxt = STEP;
      STEP:    state_nxt = burst_done ? RELEASE : ISSUE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // registered outputs and datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt          <= '0;
      rsp_valid    <= '0;
      rsp_rdata    <= '0;
      mem_addr     <= '0;
      mem_data_out <= '0;
      mem_we       <= 1'b0;
      mem_re       <= 1'b0;
      busy         <= 1'b0;
      owner        <= '0;
      rr_ptr       <= '0;
      beat_cnt     <= '0;
      last_q       <= 1'b0;
    end else begin
      busy      <= (state_nxt != IDLE);
      rsp_valid <= '0;
      unique case (state)
        IDLE: if (|req_valid) begin
          owner    <= pick;
          gnt      <= NUM_REQ'(1) << pick;
          beat_cnt <= '0;
        end
        // A requester that dropped valid before its beat started simply
        // gives up the grant; nothing is driven to memory.
        ISSUE: if (req_valid[owner]) begin
          mem_addr     <= addr_lane[owner];
          mem_data_out <= wdata_lane[owner];
          last_q       <= req_last[owner];
          mem_we       <= req_we[owner];
          mem_re       <= ~req_we[owner];
        end
        WAIT: if (mem_ready) begin
          mem_we    <= 1'b0;
          mem_re    <= 1'b0;
          if (mem_re) rsp_rdata <= mem_data_in;
          rsp_valid <= gnt;
        end
        STEP: beat_cnt <= beat_nxt[BW-1:0];
        RELEASE: begin
          gnt    <= '0;
          rr_ptr <= owner_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_npu_mem_arbiter.sv
// Bench for npu_mem_arbiter: table of single-beat arbitration vectors,
// hand-stepped corner sequences, and queue-driven burst scenarios checked
// against a transaction-order model of round-robin burst ownership.
module tb_npu_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid, req_we, req_last;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N-1:0]      gnt, rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_data_out;
  logic              mem_we, mem_re;
  logic [DW-1:0]     mem_data_in;
  logic              mem_ready;
  logic              busy;
  logic [1:0]        owner;

  npu_mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_last(req_last),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_data_out(mem_data_out),
    .mem_we(mem_we), .mem_re(mem_re),
    .mem_data_in(mem_data_in), .mem_ready(mem_ready),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  // ---------------------------------------------------------------- queues
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
    logic        last;
  } beat_t;

  typedef struct {
    int          id;
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
    int          cyc;   // actual: completion cycle; expected: gap to previous beat
  } srv_t;

  beat_t bq[N][64];
  int    bn[N];
  int    bh[N];
  srv_t  exp_q[$];
  srv_t  act_q[$];

  task automatic clear_q();
    for (int i = 0; i < N; i++) begin bn[i] = 0; bh[i] = 0; end
    exp_q.delete();
    act_q.delete();
  endtask

  task automatic push_beat(input int id, input logic [31:0] a, input logic [31:0] d,
                           input logic we, input logic last);
    bq[id][bn[id]].addr = a;
    bq[id][bn[id]].data = d;
    bq[id][bn[id]].we   = we;
    bq[id][bn[id]].last = last;
    bn[id]++;
  endtask

  // Order of service implied by the arbitration rules: starting from
  // pointer 0, the first requester with work at or after the pointer owns
  // the port until its last beat or MAX_BURST beats, then the pointer moves
  // just past it. Zero-wait spacing: 3 cycles within a grant, 5 across.
  task automatic build_model();
    int h[N];
    int p, id, n;
    srv_t s;
    for (int i = 0; i < N; i++) h[i] = 0;
    p = 0;
    while (1) begin
      id = -1;
      for (int k = N-1; k >= 0; k--)
        if (h[(p + k) % N] < bn[(p + k) % N]) id = (p + k) % N;
      if (id < 0) break;
      n = 0;
      while (1) begin
        s.id   = id;
        s.addr = bq[id][h[id]].addr;
        s.data = bq[id][h[id]].data;
        s.we   = bq[id][h[id]].we;
        s.cyc  = (n == 0) ? 5 : 3;
        exp_q.push_back(s);
        n++;
        h[id]++;
        if (bq[id][h[id]-1].last || n == MB || h[id] >= bn[id]) break;
      end
      p = (id + 1) % N;
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      if (bh[i] < bn[i]) begin
        req_valid[i]             = 1'b1;
        req_we[i]                = bq[i][bh[i]].we;
        req_last[i]              = bq[i][bh[i]].last;
        req_addr[i*AW +: AW]     = bq[i][bh[i]].addr;
        req_wdata[i*DW +: DW]    = bq[i][bh[i]].data;
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0; req_we = '0; req_last = '0;
    req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; mem_data_in = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Requesters follow their queues, memory answers after a random delay,
  // every completed beat is logged and compared with the model afterwards.
  task automatic run_engine(input string tag, input int max_wait, input int budget);
    int    cyc, wl, id, gid;
    bit    prev, strobe, done, drained;
    beat_t b;
    srv_t  s;
    cyc = 0; wl = 0; prev = 0; done = 0;
    build_model();
    drive_reqs();
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (!$onehot0(gnt)) chk({tag, "_gnt_onehot"}, gnt, 0);
      if (rsp_valid != '0) begin
        id = oh_idx(rsp_valid);
        chk({tag, "_rsp_vs_gnt"}, rsp_valid, gnt);
        if (bh[id] < bn[id]) begin
          b = bq[id][bh[id]];
          if (!b.we) chk({tag, "_rsp_rdata"}, rsp_rdata, rd_fn(b.addr));
          s.id = id; s.addr = b.addr; s.data = b.data; s.we = b.we; s.cyc = cyc;
          act_q.push_back(s);
          bh[id]++;
        end else begin
          chk({tag, "_rsp_spurious"}, rsp_valid, 0);
        end
      end
      strobe = mem_we | mem_re;
      if (strobe) begin
        if (!prev) begin
          wl  = $urandom_range(0, max_wait);
          gid = oh_idx(gnt);
          chk({tag, "_owner"}, owner, gid);
          chk({tag, "_strobe_excl"}, mem_we & mem_re, 0);
          if (bh[gid] < bn[gid]) begin
            b = bq[gid][bh[gid]];
            chk({tag, "_mem_addr"}, mem_addr, b.addr);
            chk({tag, "_mem_we"}, mem_we, b.we);
            if (b.we) chk({tag, "_mem_wdata"}, mem_data_out, b.data);
          end
        end
        if (wl == 0) begin
          mem_ready = 1'b1; mem_data_in = rd_fn(mem_addr);
        end else begin
          mem_ready = 1'b0; mem_data_in = $urandom; wl--;
        end
      end else begin
        // mem_ready outside WAIT must be ignored, so toggle it freely
        mem_ready = 1'($urandom_range(0, 1));
        mem_data_in = $urandom;
      end
      prev = strobe;
      drive_reqs();
      drained = 1;
      for (int i = 0; i < N; i++) if (bh[i] < bn[i]) drained = 0;
      done = drained && !busy && (gnt == '0);
    end
    mem_ready = 1'b0;
    chk({tag, "_completed"}, done, 1);
    chk({tag, "_beats"}, act_q.size(), exp_q.size());
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "_order_id"}, act_q[i].id, exp_q[i].id);
      chk({tag, "_order_addr"}, act_q[i].addr, exp_q[i].addr);
      if (max_wait == 0) begin
        if (i == 0) chk({tag, "_first_rsp_cyc"}, act_q[0].cyc, 3);
        else chk({tag, "_beat_gap"}, act_q[i].cyc - act_q[i-1].cyc, exp_q[i].cyc);
      end
    end
  endtask

  // ---------------------------------------------------------------- table
  typedef struct {
    logic [N-1:0] mask;
    logic         we;
    logic [N-1:0] exp_gnt;
  } vec_t;

  vec_t vt[11];

  initial begin
    int          eid;
    logic [31:0] ea;

    vt[0]  = '{4'b1111, 1'b0, 4'b0001};
    vt[1]  = '{4'b1111, 1'b1, 4'b0010};
    vt[2]  = '{4'b0001, 1'b0, 4'b0001};
    vt[3]  = '{4'b1001, 1'b1, 4'b1000};
    vt[4]  = '{4'b0110, 1'b0, 4'b0010};
    vt[5]  = '{4'b0011, 1'b1, 4'b0001};
    vt[6]  = '{4'b1100, 1'b0, 4'b0100};
    vt[7]  = '{4'b0111, 1'b1, 4'b0001};
    vt[8]  = '{4'b1000, 1'b0, 4'b1000};
    vt[9]  = '{4'b0100, 1'b1, 4'b0100};
    vt[10] = '{4'b1010, 1'b0, 4'b1000};

    // reset values
    rst_n = 1'b0;
    req_valid = '0; req_we = '0; req_last = '0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; mem_data_in = '0;
    #12;
    chk("rst_gnt", gnt, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data_out", mem_data_out, 0);
    chk("rst_strobes", {mem_we, mem_re}, 0);
    chk("rst_busy_owner", {busy, owner}, 0);
    do_reset();

    // single-beat arbitration vectors; the pointer carries across entries
    foreach (vt[t]) begin
      eid = oh_idx(vt[t].exp_gnt);
      ea  = 32'h1000 + 32'(eid * 16);
      for (int i = 0; i < N; i++) begin
        req_addr[i*AW +: AW]  = 32'h1000 + 32'(i * 16);
        req_wdata[i*DW +: DW] = 32'hA000 + 32'(i);
      end
      req_valid = vt[t].mask; req_we = {N{vt[t].we}}; req_last = '1;
      @(negedge clk);
      chk("tbl_gnt", gnt, vt[t].exp_gnt);
      chk("tbl_owner", owner, eid);
      req_valid = vt[t].mask & vt[t].exp_gnt;
      @(negedge clk);
      chk("tbl_strobes", {mem_we, mem_re}, {vt[t].we, ~vt[t].we});
      chk("tbl_mem_addr", mem_addr, ea);
      if (vt[t].we) chk("tbl_mem_wdata", mem_data_out, 32'hA000 + 32'(eid));
      mem_ready = 1'b1; mem_data_in = rd_fn(ea);
      @(negedge clk);
      chk("tbl_rsp_valid", rsp_valid, vt[t].exp_gnt);
      if (!vt[t].we) chk("tbl_rsp_rdata", rsp_rdata, rd_fn(ea));
      req_valid = '0; mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("tbl_idle", {busy, gnt}, 0);
    end

    // single read, two WAIT cycles
    do_reset();
    req_addr[0 +: AW] = 32'h100; req_we = '0; req_last = 4'b0001; req_valid = 4'b0001;
    @(negedge clk);
    chk("rd_gnt", gnt, 4'b0001);
    chk("rd_issue_strobes", {mem_we, mem_re}, 0);
    chk("rd_busy", busy, 1);
    @(negedge clk);
    chk("rd_wait1_re", {mem_we, mem_re}, 2'b01);
    chk("rd_wait1_addr", mem_addr, 32'h100);
    @(negedge clk);
    chk("rd_wait2_re", {mem_we, mem_re}, 2'b01);
    chk("rd_wait2_rsp", rsp_valid, 0);
    mem_ready = 1'b1; mem_data_in = 32'hDEADBEEF;
    @(negedge clk);
    chk("rd_rsp_valid", rsp_valid, 4'b0001);
    chk("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("rd_step_strobes", {mem_we, mem_re}, 0);
    req_valid = '0; mem_ready = 1'b0;
    @(negedge clk);
    chk("rd_release_rsp", rsp_valid, 0);
    chk("rd_release_gnt", gnt, 4'b0001);
    @(negedge clk);
    chk("rd_idle", {busy, gnt}, 0);
    chk("rd_idle_addr_kept", mem_addr, 32'h100);
    req_valid = 4'b0011;
    @(negedge clk);
    chk("rd_rr_next", gnt, 4'b0010);
    req_valid = '0;
    repeat (2) @(negedge clk);

    // withdrawn request: grant for ISSUE+RELEASE only, no memory traffic
    do_reset();
    req_valid = 4'b0100; req_last = '1;
    @(negedge clk);
    chk("wd_gnt_issue", gnt, 4'b0100);
    req_valid = '0;
    @(negedge clk);
    chk("wd_gnt_release", gnt, 4'b0100);
    chk("wd_strobes", {mem_we, mem_re}, 0);
    chk("wd_rsp", rsp_valid, 0);
    @(negedge clk);
    chk("wd_idle", {busy, gnt}, 0);
    chk("wd_owner", owner, 2);
    req_valid = 4'b1001;
    @(negedge clk);
    chk("wd_rr_next", gnt, 4'b1000);
    req_valid = '0;
    repeat (2) @(negedge clk);

    // asynchronous reset in the middle of WAIT
    do_reset();
    req_addr[0 +: AW] = 32'h40; req_we = '0; req_last = '1; req_valid = 4'b0001;
    repeat (2) @(negedge clk);
    chk("ar_wait_re", mem_re, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_async_re", mem_re, 0);
    chk("ar_async_gnt", gnt, 0);
    chk("ar_async_busy", busy, 0);
    mem_ready = 1'b1;
    @(negedge clk);
    req_valid = '0; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ar_no_rsp", rsp_valid, 0);
      chk("ar_idle", {busy, gnt, mem_re}, 0);
    end
    mem_ready = 1'b0;

    // fairness: all single-beat, zero wait, requester 0 comes back
    do_reset(); clear_q();
    push_beat(0, 32'h10, 32'h0, 1'b0, 1'b1);
    push_beat(0, 32'h14, 32'h0, 1'b0, 1'b1);
    for (int i = 1; i < N; i++) push_beat(i, 32'h10 + 32'(i * 256), 32'h0, 1'b0, 1'b1);
    run_engine("fair", 0, 200);

    // burst write on requester 1 while requester 2 waits
    do_reset(); clear_q();
    for (int k = 0; k < 4; k++) push_beat(1, 32'h200 + 32'(k * 4), 32'(k + 1), 1'b1, k == 3);
    push_beat(2, 32'h300, 32'h0, 1'b0, 1'b1);
    run_engine("burst", 0, 200);

    // forced release at MAX_BURST
    do_reset(); clear_q();
    for (int k = 0; k < 20; k++) push_beat(0, 32'h1000 + 32'(k * 4), 32'(k), 1'b0, k == 19);
    push_beat(3, 32'h3000, 32'h33, 1'b1, 1'b1);
    run_engine("maxb", 0, 400);

    // random bursts, random memory latency
    for (int r = 0; r < 4; r++) begin
      do_reset(); clear_q();
      for (int i = 0; i < N; i++) begin
        int nb, len;
        nb = $urandom_range(1, 3);
        for (int b = 0; b < nb; b++) begin
          len = $urandom_range(1, 20);
          for (int k = 0; k < len; k++)
            push_beat(i, $urandom & 32'hFFFF_FFFC, $urandom, 1'($urandom_range(0, 1)), k == len - 1);
        end
      end
      run_engine("rand", 3, 6000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
